// File: rtl/axi_sts_pkg.sv
// Shared definitions for the AXI4-Lite status/event register block.
// Contents: AXI response codes, clogb2 helper, and the index offsets of the
// STICKY and MASK control words relative to the status word count.
package axi_sts_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    CTRL_STICKY,
    CTRL_MASK
  } ctrl_reg_e;

  // Number of bits needed to represent 'value' (0 -> 0, 3 -> 2, 33 -> 6).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned result;
    v      = value;
    result = 0;
    while (v > 0) begin
      v      = v >> 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Control words sit directly after the last status word.
  function automatic int unsigned ctrl_index(input int unsigned sts_size,
                                             input ctrl_reg_e   sel);
    return (sel == CTRL_MASK) ? sts_size + 1 : sts_size;
  endfunction

endpackage

// File: rtl/axi_sts_sticky_bank.sv
// Sticky event register, interrupt mask and registered level interrupt.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   evt_in            event pulses, each set bit becomes sticky
//   wr_sticky         W1C write to the sticky register (wdata/wstrb)
//   wr_mask           byte-strobed write to the mask register
//   wdata, wstrb      write data and byte strobes
//   sticky, mask      current register contents
//   irq               |(sticky & mask), registered
module axi_sts_sticky_bank
  import axi_sts_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   evt_in,
  input  logic                    wr_sticky,
  input  logic                    wr_mask,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   sticky,
  output logic [DATA_WIDTH-1:0]   mask,
  output logic                    irq
);

  logic [DATA_WIDTH-1:0] byte_en;
  logic [DATA_WIDTH-1:0] clr;

  always_comb begin
    byte_en = '0;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
      byte_en[b*8 +: 8] = {8{wstrb[b]}};
    end
  end

  assign clr = wr_sticky ? (wdata & byte_en) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
      mask   <= '0;
      irq    <= 1'b0;
    end else begin
      // OR-ing evt_in after the clear makes a coincident event win.
      sticky <= (sticky & ~clr) | evt_in;
      if (wr_mask) begin
        mask <= (mask & ~byte_en) | (wdata & byte_en);
      end
      irq <= |(sticky & mask);
    end
  end

endmodule

// File: rtl/axi_sts_event_register.sv
// AXI4-Lite status block: read-only status words taken from a wide sts_data
// bus, a W1C sticky event register, a R/W interrupt mask and a level irq.
// Word map (index = addr[ADDR_LSB +: IDX_W], upper address bits alias):
//   0..STS_SIZE-1  status words (read-only, writes -> SLVERR)
//   STS_SIZE       STICKY (read, write-1-to-clear with byte strobes)
//   STS_SIZE+1     MASK   (read/write with byte strobes)
//   other          read 0 / SLVERR, write ignored / SLVERR
// Ports: aclk, aresetn (async active-low), sts_data, evt_in, irq and a
// standard AXI4-Lite slave (s_axi_aw*, s_axi_w*, s_axi_b*, s_axi_ar*, s_axi_r*).
// Build option AXI_STS_SNAPSHOT_EN: a read of word 0 latches words
// 1..STS_SIZE-1 into a shadow that later reads of those words return.
module axi_sts_event_register
  import axi_sts_pkg::*;
#(
  parameter int unsigned STS_DATA_WIDTH = 1024,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [STS_DATA_WIDTH-1:0]   sts_data,
  input  logic [AXI_DATA_WIDTH-1:0]   evt_in,
  output logic                        irq,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                  s_axi_awprot,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready
);

  localparam int unsigned W        = AXI_DATA_WIDTH;
  localparam int unsigned STRB_W   = W / 8;
  localparam int unsigned STS_SIZE = STS_DATA_WIDTH / W;
  localparam int unsigned ADDR_LSB = clogb2(W / 8 - 1);
  localparam int unsigned IDX_W    = clogb2(STS_SIZE + 1);

  localparam logic [IDX_W-1:0] STICKY_IDX = IDX_W'(ctrl_index(STS_SIZE, CTRL_STICKY));
  localparam logic [IDX_W-1:0] MASK_IDX   = IDX_W'(ctrl_index(STS_SIZE, CTRL_MASK));

  // Write channel state
  logic              aw_held;
  logic              w_held;
  logic [IDX_W-1:0]  widx;
  logic [W-1:0]      wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_hs;
  logic              w_hs;
  logic              wr_exec;
  logic              wr_sticky;
  logic              wr_mask;

  // Read channel
  logic [IDX_W-1:0]  rd_idx;
  logic              ar_hs;
  logic [W-1:0]      rd_word;
  logic [1:0]        rd_resp;

  logic [W-1:0]      sticky;
  logic [W-1:0]      mask;
  logic [STS_DATA_WIDTH-1:0] sts_view;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr, s_axi_araddr, s_axi_awprot, s_axi_arprot};

  // ---------------------------------------------------------------- write
  assign s_axi_awready = ~aw_held & ~s_axi_bvalid;
  assign s_axi_wready  = ~w_held & ~s_axi_bvalid;
  assign aw_hs         = s_axi_awvalid & s_axi_awready;
  assign w_hs          = s_axi_wvalid & s_axi_wready;

  // Executes for exactly one cycle: bvalid rises at the same edge and
  // blocks re-execution until the response is taken.
  assign wr_exec   = aw_held & w_held & ~s_axi_bvalid;
  assign wr_sticky = wr_exec && (widx == STICKY_IDX);
  assign wr_mask   = wr_exec && (widx == MASK_IDX);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      widx         <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        widx    <= s_axi_awaddr[ADDR_LSB +: IDX_W];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (wr_exec) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= (wr_sticky || wr_mask) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end
    end
  end

  axi_sts_sticky_bank #(
    .DATA_WIDTH (W)
  ) u_sticky_bank (
    .clk       (aclk),
    .rst_n     (aresetn),
    .evt_in    (evt_in),
    .wr_sticky (wr_sticky),
    .wr_mask   (wr_mask),
    .wdata     (wdata_q),
    .wstrb     (wstrb_q),
    .sticky    (sticky),
    .mask      (mask),
    .irq       (irq)
  );

  // ----------------------------------------------------------------- read
  assign s_axi_arready = ~s_axi_rvalid;
  assign ar_hs         = s_axi_arvalid & s_axi_arready;
  assign rd_idx        = s_axi_araddr[ADDR_LSB +: IDX_W];

`ifdef AXI_STS_SNAPSHOT_EN
  logic [STS_DATA_WIDTH-W-1:0] shadow;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      shadow <= '0;
    end else if (ar_hs && (rd_idx == '0)) begin
      shadow <= sts_data[STS_DATA_WIDTH-1:W];
    end
  end

  // Word 0 is always live; the rest come from the last word-0 snapshot.
  assign sts_view = {shadow, sts_data[W-1:0]};
`else
  assign sts_view = sts_data;
`endif

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_SLVERR;
    for (int unsigned j = 0; j < STS_SIZE; j++) begin
      if (rd_idx == IDX_W'(j)) begin
        rd_word = sts_view[j*W +: W];
        rd_resp = RESP_OKAY;
      end
    end
    if (rd_idx == STICKY_IDX) begin
      rd_word = sticky;
      rd_resp = RESP_OKAY;
    end
    if (rd_idx == MASK_IDX) begin
      rd_word = mask;
      rd_resp = RESP_OKAY;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_word;
      s_axi_rresp  <= rd_resp;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_sts_event_register.sv
// Self-checking bench for axi_sts_event_register with default parameters
// (1024-bit status bus, 32-bit AXI data, 16-bit address). Expected read and
// write responses are queued by the stimulus tasks and compared by a monitor
// process when the DUT presents rvalid/bvalid with the matching ready.
module tb_axi_sts_event_register;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam int LIMIT = 20;

  logic          aclk;
  logic          aresetn;
  logic [1023:0] sts_data;
  logic [31:0]   evt_in;
  logic          irq;
  logic [15:0]   awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [15:0]   araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  axi_sts_event_register #(
    .STS_DATA_WIDTH (1024),
    .AXI_DATA_WIDTH (32),
    .AXI_ADDR_WIDTH (16)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .sts_data      (sts_data),
    .evt_in        (evt_in),
    .irq           (irq),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp_v;
  } chk_t;

  chk_t        cq[$];
  logic [33:0] rq[$];
  logic [1:0]  bq[$];
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp_v);
    chk_t c;
    c.name  = name;
    c.act   = act;
    c.exp_v = exp_v;
    cq.push_back(c);
  endfunction

  // Monitor: all comparisons and both counters live here.
  always @(negedge aclk) begin
    chk_t        c;
    logic [33:0] er;
    logic [1:0]  eb;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      checks++;
      if (c.act !== c.exp_v) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, c.act, c.exp_v);
      end
    end
    if (aresetn && rvalid && rready) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got rresp=%0d rdata=0x%08h expected no response", rresp, rdata);
      end else begin
        er = rq.pop_front();
        if ({rresp, rdata} !== er) begin
          errors++;
          $display("FAIL rd_resp: got rresp=%0d rdata=0x%08h expected rresp=%0d rdata=0x%08h",
                   rresp, rdata, er[33:32], er[31:0]);
        end
      end
    end
    if (aresetn && bvalid && bready) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got bresp=%0d expected no response", bresp);
      end else begin
        eb = bq.pop_front();
        if (bresp !== eb) begin
          errors++;
          $display("FAIL wr_resp: got bresp=%0d expected bresp=%0d", bresp, eb);
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_evt(input logic [31:0] v);
    evt_in = v;
    tick();
    evt_in = '0;
  endtask

  task automatic axi_read(input logic [15:0] addr, input logic [31:0] exp_d,
                          input logic [1:0] exp_r, input int hold);
    int n;
    rq.push_back({exp_r, exp_d});
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < LIMIT) begin tick(); n++; end
    chk("arready_wait", 64'(n < LIMIT), 1);
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("r_hold_data", rdata, exp_d);
      chk("r_hold_arready", arready, 0);
      tick();
    end
    rready = 1'b1;
    n = 0;
    while (!rvalid && n < LIMIT) begin tick(); n++; end
    chk("rvalid_wait", 64'(n < LIMIT), 1);
    tick();
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead,
                           input logic [1:0] exp_resp, output logic irq_at_b);
    int n;
    bq.push_back(exp_resp);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    if (w_lead > 0) begin
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < LIMIT) begin tick(); n++; end
      chk("wready_wait", 64'(n < LIMIT), 1);
      tick();
      wvalid = 1'b0;
      repeat (w_lead - 1) tick();
      awvalid = 1'b1;
      n = 0;
      while (!awready && n < LIMIT) begin tick(); n++; end
      chk("awready_wait", 64'(n < LIMIT), 1);
      tick();
      awvalid = 1'b0;
    end else begin
      awvalid = 1'b1;
      wvalid  = 1'b1;
      n = 0;
      while (!(awready && wready) && n < LIMIT) begin tick(); n++; end
      chk("aw_w_ready_wait", 64'(n < LIMIT), 1);
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < LIMIT) begin tick(); n++; end
    chk("bvalid_wait", 64'(n < LIMIT), 1);
    irq_at_b = irq;
    tick();
    bready = 1'b0;
  endtask

  localparam logic [15:0] A_STICKY = 16'(32 * 4);
  localparam logic [15:0] A_MASK   = 16'(33 * 4);
  localparam logic [15:0] A_UNMAP  = 16'(34 * 4);

  initial begin
    logic        ib;
    logic [31:0] exp_w1;
    int          n;

    aresetn  = 1'b0;
    sts_data = '0;
    evt_in   = '0;
    awaddr   = '0;
    awprot   = '0;
    awvalid  = 1'b0;
    wdata    = '0;
    wstrb    = '0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    araddr   = '0;
    arprot   = '0;
    arvalid  = 1'b0;
    rready   = 1'b0;
    repeat (3) tick();

    chk("rst_awready", awready, 1);
    chk("rst_wready",  wready,  1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_rvalid",  rvalid,  0);
    chk("rst_bresp",   bresp,   0);
    chk("rst_rresp",   rresp,   0);
    chk("rst_rdata",   rdata,   0);
    chk("rst_irq",     irq,     0);
    aresetn = 1'b1;

    sts_data[0*32 +: 32] = 32'h0BADF00D;
    sts_data[1*32 +: 32] = 32'h00000011;
    sts_data[2*32 +: 32] = 32'h22222222;
    sts_data[3*32 +: 32] = 32'hDEADBEEF;
    tick();

    // Reset in the middle of a read with rvalid held
    axi_write(A_MASK, 32'h000000FF, 4'hF, 0, OKAY, ib);
    pulse_evt(32'h3);
    axi_read(A_STICKY, 32'h3, OKAY, 0);
    chk("pre_reset_irq", irq, 1);
    araddr  = A_STICKY;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("pre_reset_rvalid", rvalid, 1);
    #2 aresetn = 1'b0;
    #1 chk("reset_drops_rvalid", rvalid, 0);
    chk("reset_drops_irq", irq, 0);
    tick();
    aresetn = 1'b1;
    tick();
    chk("post_reset_arready", arready, 1);
    axi_read(A_STICKY, 32'h0, OKAY, 0);
    axi_read(A_MASK,   32'h0, OKAY, 0);

    // Status words: word 0 first (primes the snapshot), word 3 with stalled rready, alias
    axi_read(16'h0000, 32'h0BADF00D, OKAY, 0);
    axi_read(16'h000C, 32'hDEADBEEF, OKAY, 4);
    axi_read(16'h010C, 32'hDEADBEEF, OKAY, 0);

    // Sticky/mask/irq: event coincident with W1C keeps the bit set
    pulse_evt(32'h5);
    repeat (2) tick();
    chk("irq_masked_off", irq, 0);
    axi_write(A_MASK, 32'h4, 4'hF, 0, OKAY, ib);
    chk("irq_after_mask", irq, 1);
    evt_in = 32'h4;
    axi_write(A_STICKY, 32'h4, 4'hF, 0, OKAY, ib);
    evt_in = '0;
    axi_read(A_STICKY, 32'h5, OKAY, 0);
    chk("irq_set_wins", irq, 1);

    // Clear without a coincident event
    axi_write(A_STICKY, 32'h4, 4'hF, 0, OKAY, ib);
    chk("irq_at_clear_resp", ib, 1);
    chk("irq_after_clear", irq, 0);
    axi_read(A_STICKY, 32'h1, OKAY, 0);

    // Errors: write to status word with W leading AW, unmapped read/write
    axi_write(16'h0000, 32'hFFFFFFFF, 4'hF, 3, SLVERR, ib);
    axi_read(16'h0000, 32'h0BADF00D, OKAY, 0);
    axi_read(A_UNMAP, 32'h0, SLVERR, 0);
    axi_write(A_UNMAP, 32'h12345678, 4'hF, 0, SLVERR, ib);

    // Byte strobes on MASK and on the W1C path
    axi_write(A_MASK, 32'hAABBCCDD, 4'b0110, 0, OKAY, ib);
    axi_read(A_MASK, 32'h00BBCC04, OKAY, 0);
    pulse_evt(32'hFF00FF00);
    axi_write(A_STICKY, 32'hFFFFFFFF, 4'b1000, 1, OKAY, ib);
    axi_read(A_STICKY, 32'h0000FF01, OKAY, 0);

    // Coherent snapshot
    axi_read(16'h0000, 32'h0BADF00D, OKAY, 0);
    sts_data[1*32 +: 32] = 32'h00000022;
`ifdef AXI_STS_SNAPSHOT_EN
    exp_w1 = 32'h00000011;
`else
    exp_w1 = 32'h00000022;
`endif
    tick();
    axi_read(16'h0004, exp_w1, OKAY, 0);

    n = 0;
    while ((rq.size() != 0 || bq.size() != 0 || cq.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", 64'(rq.size() + bq.size()), 0);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sts_event_register.md
# axi_sts_event_register

Parametrised AXI4-Lite status block, successor to the plain read-only status register. Exposes a wide `sts_data` bus as read-only words, adds a sticky event register with write-1-to-clear, a R/W interrupt mask and a level interrupt output, and can latch a coherent snapshot of the whole status bus. Sits between the PS AXI interconnect and PL status/event sources; fully handshake-compliant on all five channels.

## Interface
- `STS_DATA_WIDTH`, 1024: status bus width; a multiple of `AXI_DATA_WIDTH`.
- `AXI_DATA_WIDTH`, 32: AXI data width; 32 or 64.
- `AXI_ADDR_WIDTH`, 16: AXI address width.
- Derived: `STS_SIZE = STS_DATA_WIDTH/AXI_DATA_WIDTH`; `ADDR_LSB = clogb2(AXI_DATA_WIDTH/8-1)`; `IDX_W = clogb2(STS_SIZE+1)`.

Ports:
- `aclk` in 1: single clock.
- `aresetn` in 1: reset, asynchronous assert, active-low.
- `sts_data` in `STS_DATA_WIDTH`: live status bits.
- `evt_in` in `AXI_DATA_WIDTH`: event pulses; each set bit is made sticky.
- `irq` out 1: `|(sticky & mask)`, registered.
- `s_axi_aw*`, `s_axi_w*` (incl. `s_axi_wstrb`, `AXI_DATA_WIDTH/8`), `s_axi_b*`, `s_axi_ar*`, `s_axi_r*`: AXI4-Lite slave with standard widths and directions.

## Operation
- Word index = `addr[ADDR_LSB+IDX_W-1:ADDR_LSB]`. Bits above the field are ignored, so the map aliases.
- Index 0..STS_SIZE-1: status words, read-only. Word j is `sts_data[j*W +: W]`.
- Index STS_SIZE: STICKY. Reads return the sticky bits. A write clears each bit where `wdata=1` and its byte strobe is set.
- Index STS_SIZE+1: MASK, R/W, byte strobes honoured.
- Any other index: read returns rdata 0 and rresp SLVERR (2'b10).
- A write to a status word or to an unmapped index has no effect and returns bresp SLVERR. All other accesses return OKAY.
- Sticky update each cycle: `sticky <= (sticky & ~clr) | evt_in`. If an event arrives in the same cycle as a clear, the set wins.
- Write channel:
  - `awready = ~aw_held & ~bvalid`; `wready = ~w_held & ~bvalid`. AW and W are accepted independently, in either order.
  - When both are held, the write executes and `bvalid` rises the next cycle.
  - `bvalid` stays high until `bready`, and the held flags clear then.
  - Only one write is outstanding at a time.
- Read channel:
  - `arready = ~rvalid`.
  - On an AR handshake, `rdata`/`rresp` are registered and `rvalid` rises the next cycle.
  - `rdata`, `rresp` and `rvalid` stay stable until `rready`.

## Timing
- Reset values: `awready`=1, `wready`=1, `arready`=1, `bvalid`=0, `rvalid`=0, `bresp`=0, `rresp`=0, `rdata`=0, `irq`=0. Sticky, mask and snapshot shadow all reset to 0.
- Reset assertion mid-transaction immediately drops any pending bvalid/rvalid and discards held AW/W.
- Read latency is 1 cycle from AR handshake to rvalid. Sustained read rate is one per 2 cycles.
- Write latency is 1 cycle from the later of the AW/W handshakes to bvalid.
- `irq` reflects sticky/mask changes 1 cycle after they are registered, i.e. 2 cycles after `evt_in`.
- If a read of STICKY and a W1C write complete in the same cycle, the read returns the pre-clear value.

## Configuration
- `AXI_STS_SNAPSHOT_EN` defined:
  - Accepting a read of word 0 returns live word 0 and, in the same edge, latches words 1..STS_SIZE-1 into a shadow register.
  - Reads of words 1..STS_SIZE-1 return the shadow, giving a coherent multi-word view.
- Undefined: no shadow is built and every status read returns live `sts_data`.

## Structure
- Package `axi_sts_pkg`: `RESP_OKAY`, `RESP_SLVERR`, the `clogb2` function, and a function returning the STICKY/MASK index offsets.
- One sub-module, `axi_sts_sticky_bank`: sticky/mask registers, W1C with strobes, and the `irq` register.
- AXI channel logic and the read mux stay in the top module.

## Test plan
- Reset mid-read, with `rvalid`=1 and `rready`=0: assert `aresetn`=0 → `rvalid`=0 immediately; after release `arready`=1 and sticky/mask read 0.
- Read word 3 (addr 0x0C) with `sts_data` word 3 = 0xDEADBEEF, `rready` held low for 4 cycles → `rdata` stable at 0xDEADBEEF, rresp OKAY, `arready`=0 until `rready`.
- Pulse `evt_in`=0x5; write MASK=0x4, then STICKY=0x4 concurrently with `evt_in`=0x4 → sticky stays 0x5 and `irq` stays 1.
- Then write STICKY=0x4 with no event → sticky=0x1, `irq` drops 2 cycles later.
- W data presented 3 cycles before AW, write to word 0 → bresp SLVERR, word 0 unchanged. Read of index STS_SIZE+2 → rdata 0, rresp SLVERR.
- With `AXI_STS_SNAPSHOT_EN`: read word 0, then change `sts_data` word 1 from 0x11 to 0x22, then read word 1 → returns 0x11. Without the macro the same sequence returns 0x22.
